// File: rtl/carus_clk_gate_pkg.sv
// Shared types and constants for the Carus automatic clock-gating controller.
package carus_clk_gate_pkg;

    // Controller states: clock running, clock stopped, clock restarted but
    // requests still held off while the gated domain settles.
    typedef enum logic [1:0] {
        ON    = 2'd0,
        GATED = 2'd1,
        WAKE  = 2'd2
    } cg_state_e;

    // Wake counter width; large enough for WAKE_CYCLES up to 15.
    localparam int WAKE_CNT_W = 4;

endpackage

// File: rtl/carus_clk_gate_ctrl.sv
// Automatic clock-gating controller for the Carus clock-gate cell.
// Runs on the free-running clock, stops the gated clock after a programmable
// idle period and restarts it on new activity, holding requests off for
// WAKE_CYCLES cycles (legal range 1..15) after the clock comes back.
//
// Request handshake: a transfer completes on the rising clk_i edge where
// req_valid_i && req_ready_o are both 1. The requester keeps req_valid_i high
// until that edge; req_ready_o never drops while the controller is in ON.
//
// clk_en_o, gated_o and req_ready_o are flops loaded from the next-state
// decode, so they carry no combinational path from any input and the
// clock-gate latch sees a glitch-free enable. Together they also make the
// FSM state directly observable: ON=(1,0,1), GATED=(0,1,0), WAKE=(1,0,0).
module carus_clk_gate_ctrl
    import carus_clk_gate_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int WAKE_CYCLES = 2,
    parameter int STAT_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cfg_en_i,
    input  logic              force_on_i,
    input  logic [CNT_W-1:0]  cfg_idle_thr_i,
    input  logic              busy_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    output logic              clk_en_o,
    output logic              gated_o,
    output logic [STAT_W-1:0] gate_cnt_o
);

    localparam logic [WAKE_CNT_W-1:0] WAKE_LOAD = WAKE_CNT_W'(WAKE_CYCLES - 1);

    cg_state_e              state_q, state_d;
    logic [CNT_W-1:0]       idle_cnt_q, idle_cnt_d;
    logic [WAKE_CNT_W-1:0]  wake_cnt_q, wake_cnt_d;
    logic [STAT_W-1:0]      gate_cnt_q, gate_cnt_d;
    logic                   clk_en_d, gated_d, ready_d;
    logic                   activity;

    // Anything that needs the clock running counts as activity.
    assign activity = busy_i | req_valid_i | force_on_i | ~cfg_en_i;

    // State, counters and registered outputs; reset puts the clock back on at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ON;
            idle_cnt_q  <= '0;
            wake_cnt_q  <= '0;
            gate_cnt_q  <= '0;
            clk_en_o    <= 1'b1;
            gated_o     <= 1'b0;
            req_ready_o <= 1'b1;
        end else begin
            state_q     <= state_d;
            idle_cnt_q  <= idle_cnt_d;
            wake_cnt_q  <= wake_cnt_d;
            gate_cnt_q  <= gate_cnt_d;
            clk_en_o    <= clk_en_d;
            gated_o     <= gated_d;
            req_ready_o <= ready_d;
        end
    end

    // Next-state, counter updates and the output decode of the next state.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        gate_cnt_d = gate_cnt_q;

        unique case (state_q)
            ON: begin
                if (activity) begin
                    // Activity wins even on the threshold cycle.
                    idle_cnt_d = '0;
                end else if (idle_cnt_q >= cfg_idle_thr_i) begin
                    state_d    = GATED;
                    idle_cnt_d = '0;
                    if (gate_cnt_q != {STAT_W{1'b1}}) begin
                        gate_cnt_d = gate_cnt_q + STAT_W'(1);
                    end
                end else begin
                    // Held below the threshold by the compare above, so no wrap.
                    idle_cnt_d = idle_cnt_q + CNT_W'(1);
                end
            end
            GATED: begin
                if (activity) begin
                    state_d    = WAKE;
                    wake_cnt_d = WAKE_LOAD;
                end
            end
            WAKE: begin
                // Activity is irrelevant here: the clock is already running.
                if (wake_cnt_q == '0) begin
                    state_d = ON;
                end else begin
                    wake_cnt_d = wake_cnt_q - WAKE_CNT_W'(1);
                end
            end
            default: begin
                state_d = ON;
            end
        endcase

        clk_en_d = (state_d != GATED);
        gated_d  = (state_d == GATED);
        ready_d  = (state_d == ON);
    end

    assign gate_cnt_o = gate_cnt_q;

endmodule
